// File: rtl/fp_sp_to_i32.sv
// FloPoCo single-precision (34-bit) to signed int32 converter, 0..3 register stages.
// Define FP_SP_TO_I32_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fp_sp_to_i32 #(
    parameter int NUM_STAGES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        in_valid,
    input  logic [33:0] X,
    output logic [31:0] R,
    output logic        out_valid,
    output logic        invalid
);

    typedef struct packed {
        logic        valid;
        logic        sat;
        logic        sat_neg;
        logic        bad;
        logic        zero;
        logic        sign;
        logic [7:0]  expo;
        logic [23:0] mant;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic        sat;
        logic        sat_neg;
        logic        bad;
        logic        sign;
        logic [31:0] mag;
    } shf_t;

    dec_t        dec_next;
    dec_t        dec_cur;
    shf_t        shf_next;
    shf_t        shf_cur;
    logic [31:0] res_next;

    generate
        if (NUM_STAGES < 0 || NUM_STAGES > 3) begin : g_bad_num_stages
            $error("fp_sp_to_i32: NUM_STAGES must be 0, 1, 2 or 3");
        end
    endgenerate

    // Decode and classify; anything that ends in a constant result is flagged as sat/zero here.
    always_comb begin
        dec_next       = '0;
        dec_next.valid = in_valid;
        dec_next.sign  = X[31];
        dec_next.expo  = X[30:23];
        dec_next.mant  = {1'b1, X[22:0]};
        case (X[33:32])
            2'b00: dec_next.zero = 1'b1;
            2'b01: begin
                if (X[30:23] >= 8'd158) begin
                    dec_next.sat     = 1'b1;
                    dec_next.sat_neg = X[31];
                    // -2^31 is the one e=31 value that is exactly representable
                    dec_next.bad     = !(X[31] && (X[30:23] == 8'd158) && (X[22:0] == 23'd0));
                end
            end
            2'b10: begin
                dec_next.sat     = 1'b1;
                dec_next.sat_neg = X[31];
                dec_next.bad     = 1'b1;
            end
            default: begin
                dec_next.sat     = 1'b1;
                dec_next.sat_neg = 1'b1;
                dec_next.bad     = 1'b1;
            end
        endcase
    end

    generate
        if (NUM_STAGES >= 2) begin : g_dec_reg
            dec_t dec_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dec_reg <= '0;
                end else if (ce) begin
                    if (dec_next.valid) dec_reg <= dec_next;
                    else                dec_reg.valid <= 1'b0;
                end
            end
            assign dec_cur = dec_reg;
        end else begin : g_dec_comb
            assign dec_cur = dec_next;
        end
    endgenerate

    // Shifter: left for e>=23 (exact), right otherwise with the shift clamped at 25,
    // which already pushes the whole mantissa below the guard position.
    logic [31:0] mag;
    logic [7:0]  rsh;
    logic [4:0]  rsh_c;
`ifdef FP_SP_TO_I32_RNE_EN
    logic [47:0] ext;
    logic        round_up;
`endif

    always_comb begin
        shf_next         = '0;
        shf_next.valid   = dec_cur.valid;
        shf_next.sat     = dec_cur.sat;
        shf_next.sat_neg = dec_cur.sat_neg;
        shf_next.bad     = dec_cur.bad;
        shf_next.sign    = dec_cur.sign;
        mag              = '0;
        rsh              = '0;
        rsh_c            = '0;
`ifdef FP_SP_TO_I32_RNE_EN
        ext              = '0;
        round_up         = 1'b0;
`endif
        if (dec_cur.zero || dec_cur.sat) begin
            mag = '0;
        end else if (dec_cur.expo >= 8'd150) begin
            mag = {8'd0, dec_cur.mant} << (dec_cur.expo - 8'd150);
        end else begin
            rsh   = 8'd150 - dec_cur.expo;
            rsh_c = (rsh > 8'd25) ? 5'd25 : rsh[4:0];
`ifdef FP_SP_TO_I32_RNE_EN
            ext      = {dec_cur.mant, 24'd0} >> rsh_c;
            mag      = {8'd0, ext[47:24]};
            round_up = ext[23] && ((|ext[22:0]) || ext[24]);
            mag      = mag + {31'd0, round_up};
`else
            mag = {8'd0, dec_cur.mant >> rsh_c};
`endif
        end
        shf_next.mag = mag;
    end

    generate
        if (NUM_STAGES == 3) begin : g_shf_reg
            shf_t shf_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shf_reg <= '0;
                end else if (ce) begin
                    if (shf_next.valid) shf_reg <= shf_next;
                    else                shf_reg.valid <= 1'b0;
                end
            end
            assign shf_cur = shf_reg;
        end else begin : g_shf_comb
            assign shf_cur = shf_next;
        end
    endgenerate

    always_comb begin
        res_next = '0;
        if (shf_cur.sat)
            res_next = shf_cur.sat_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            res_next = shf_cur.sign ? (32'd0 - shf_cur.mag) : shf_cur.mag;
    end

    generate
        if (NUM_STAGES == 0) begin : g_out_comb
            assign R         = res_next;
            assign invalid   = shf_cur.bad;
            assign out_valid = shf_cur.valid;
        end else begin : g_out_reg
            logic [31:0] r_reg;
            logic        invalid_reg;
            logic        valid_reg;
            // Bubbles leave R/invalid at their last value; only valid_reg tracks them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_reg       <= '0;
                    invalid_reg <= 1'b0;
                    valid_reg   <= 1'b0;
                end else if (ce) begin
                    valid_reg <= shf_cur.valid;
                    if (shf_cur.valid) begin
                        r_reg       <= res_next;
                        invalid_reg <= shf_cur.bad;
                    end
                end
            end
            assign R         = r_reg;
            assign invalid   = invalid_reg;
            assign out_valid = valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fp_sp_to_i32.sv
// Self-checking bench for fp_sp_to_i32: directed table (1 stage), stall/reset sequences
// (3 stages) and random stream on both against a real-arithmetic reference model.
module tb_fp_sp_to_i32;

`ifdef FP_SP_TO_I32_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce1, v1, ov1, inv1;
    logic        ce3, v3, ov3, inv3;
    logic [33:0] x1, x3;
    logic [31:0] r1, r3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_sp_to_i32 #(.NUM_STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce1), .in_valid(v1), .X(x1),
        .R(r1), .out_valid(ov1), .invalid(inv1)
    );

    fp_sp_to_i32 #(.NUM_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ce(ce3), .in_valid(v3), .X(x3),
        .R(r3), .out_valid(ov3), .invalid(inv3)
    );

    typedef struct {
        logic [33:0] x;
        logic [31:0] r;
        logic        bad;
    } vec_t;

    vec_t tbl [24];

    function automatic logic [33:0] mk(input logic [1:0] exn, input logic s,
                                       input logic [7:0] e, input logic [22:0] f);
        return {exn, s, e, f};
    endfunction

    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
        else        for (int i = 0; i < -k; i++) p = p / 2.0;
        return p;
    endfunction

    // Reference: value as a real number, range check, then truncate or round-half-even.
    function automatic void model(input logic [33:0] x, output logic [31:0] r, output logic bad);
        real    v, sv, fr;
        longint t;
        r   = '0;
        bad = 1'b0;
        case (x[33:32])
            2'b00: ;
            2'b11: begin r = 32'h8000_0000; bad = 1'b1; end
            2'b10: begin r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; bad = 1'b1; end
            default: begin
                v  = (8388608.0 + real'(x[22:0])) * pow2(int'(x[30:23]) - 150);
                sv = x[31] ? -v : v;
                if (sv >= 2147483648.0) begin
                    r = 32'h7FFF_FFFF; bad = 1'b1;
                end else if (sv < -2147483648.0) begin
                    r = 32'h8000_0000; bad = 1'b1;
                end else begin
                    t  = longint'($floor(v));
                    fr = v - real'(t);
                    if (RNE && (fr > 0.5 || (fr == 0.5 && t[0]))) t = t + 1;
                    r = x[31] ? 32'(-t) : 32'(t);
                end
            end
        endcase
    endfunction

    function automatic logic [33:0] rand_x();
        logic [1:0]  exn;
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k   = $urandom_range(0, 11);
        exn = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b01;
        e   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(115, 162));
        f   = 23'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            f = f & 23'h700000;
            e = 8'($urandom_range(125, 132));
        end
        return mk(exn, 1'($urandom), e, f);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    logic [32:0] q1[$];
    logic [32:0] q3[$];
    logic [32:0] e33;
    logic [31:0] er;
    logic        eb;

    // stall schedule for the 3-stage instance
    logic        s_ce [12];
    logic        s_v  [12];
    logic [33:0] s_x  [12];
    int          got_val [$];
    int          got_cyc [$];
    logic [31:0] prev_r;
    logic        prev_ov;
    int          stale;

    initial begin
        tbl[0]  = '{mk(2'b01, 1'b0, 8'd127, 23'd0),        32'h0000_0001, 1'b0};
        tbl[1]  = '{mk(2'b01, 1'b1, 8'd127, 23'd0),        32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{mk(2'b01, 1'b0, 8'd157, 23'd0),        32'h4000_0000, 1'b0};
        tbl[3]  = '{mk(2'b01, 1'b1, 8'd158, 23'd0),        32'h8000_0000, 1'b0};
        tbl[4]  = '{mk(2'b10, 1'b0, 8'd255, 23'd0),        32'h7FFF_FFFF, 1'b1};
        tbl[5]  = '{mk(2'b10, 1'b1, 8'd255, 23'd0),        32'h8000_0000, 1'b1};
        tbl[6]  = '{mk(2'b11, 1'b0, 8'd255, 23'd1),        32'h8000_0000, 1'b1};
        tbl[7]  = '{mk(2'b00, 1'b0, 8'd0,   23'd0),        32'h0000_0000, 1'b0};
        tbl[8]  = '{mk(2'b00, 1'b1, 8'd0,   23'd0),        32'h0000_0000, 1'b0};
        tbl[9]  = '{mk(2'b00, 1'b1, 8'd200, 23'd5),        32'h0000_0000, 1'b0};
        tbl[10] = '{mk(2'b01, 1'b0, 8'd158, 23'd0),        32'h7FFF_FFFF, 1'b1};
        tbl[11] = '{mk(2'b01, 1'b0, 8'd157, 23'h7FFFFF),   32'h7FFF_FF80, 1'b0};
        tbl[12] = '{mk(2'b01, 1'b1, 8'd159, 23'd0),        32'h8000_0000, 1'b1};
        tbl[13] = '{mk(2'b01, 1'b1, 8'd158, 23'd1),        32'h8000_0000, 1'b1};
        tbl[14] = '{mk(2'b01, 1'b0, 8'd128, 23'h200000),   32'd2, 1'b0};
        tbl[15] = '{mk(2'b01, 1'b0, 8'd128, 23'h600000),   RNE ? 32'd4 : 32'd3, 1'b0};
        tbl[16] = '{mk(2'b01, 1'b1, 8'd128, 23'h300000),   RNE ? 32'hFFFF_FFFD : 32'hFFFF_FFFE, 1'b0};
        tbl[17] = '{mk(2'b01, 1'b0, 8'd126, 23'd0),        32'd0, 1'b0};
        tbl[18] = '{mk(2'b01, 1'b0, 8'd126, 23'h400000),   RNE ? 32'd1 : 32'd0, 1'b0};
        tbl[19] = '{mk(2'b01, 1'b0, 8'd127, 23'h400000),   RNE ? 32'd2 : 32'd1, 1'b0};
        tbl[20] = '{mk(2'b01, 1'b1, 8'd128, 23'h200000),   32'hFFFF_FFFE, 1'b0};
        tbl[21] = '{mk(2'b01, 1'b1, 8'd10,  23'h12345),    32'd0, 1'b0};
        tbl[22] = '{mk(2'b01, 1'b0, 8'd150, 23'h7FFFFF),   32'h00FF_FFFF, 1'b0};
        tbl[23] = '{mk(2'b01, 1'b1, 8'd100, 23'h0),        32'd0, 1'b0};

        rst_n = 1'b0;
        ce1 = 1'b0; v1 = 1'b0; x1 = '0;
        ce3 = 1'b0; v3 = 1'b0; x3 = '0;
        #12;
        chk("reset ov1", {31'd0, ov1}, 32'd0);
        chk("reset r1", r1, 32'd0);
        chk("reset inv1", {31'd0, inv1}, 32'd0);
        chk("reset ov3", {31'd0, ov3}, 32'd0);
        chk("reset r3", r3, 32'd0);
        chk("reset inv3", {31'd0, inv3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ce3 = 1'b1;

        // Directed table through the single-stage instance.
        for (int i = 0; i < 24; i++) begin
            x1 = tbl[i].x; v1 = 1'b1; ce1 = 1'b1;
            @(posedge clk); #1;
            $display("vec%0d X=%h R=%h inv=%b ov=%b", i, tbl[i].x, r1, inv1, ov1);
            chk($sformatf("vec%0d R", i), r1, tbl[i].r);
            chk($sformatf("vec%0d invalid", i), {31'd0, inv1}, {31'd0, tbl[i].bad});
            chk($sformatf("vec%0d out_valid", i), {31'd0, ov1}, 32'd1);
        end
        v1 = 1'b0;
        @(posedge clk); #1;
        chk("bubble ov1", {31'd0, ov1}, 32'd0);

        // Stall/bubble sequence on the three-stage instance.
        for (int c = 0; c < 12; c++) begin
            s_ce[c] = 1'b1; s_v[c] = 1'b0; s_x[c] = mk(2'b01, 1'b0, 8'd127, 23'd0);
        end
        s_v[0] = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            s_ce[c] = 1'b0; s_v[c] = 1'b1; s_x[c] = mk(2'b01, 1'b0, 8'd128, 23'd0);
        end
        s_v[5] = 1'b1; s_x[5] = mk(2'b01, 1'b0, 8'd128, 23'd0);
        s_v[6] = 1'b1; s_x[6] = mk(2'b01, 1'b0, 8'd128, 23'h400000);
        for (int c = 0; c < 12; c++) begin
            ce3 = s_ce[c]; v3 = s_v[c]; x3 = s_x[c];
            prev_r = r3; prev_ov = ov3;
            @(posedge clk); #1;
            $display("stall c=%0d ce=%b in_valid=%b R=%h ov=%b", c, s_ce[c], s_v[c], r3, ov3);
            if (s_ce[c] && ov3) begin
                got_val.push_back(int'(r3));
                got_cyc.push_back(c);
            end
            if (!s_ce[c]) begin
                chk($sformatf("stall hold R c%0d", c), r3, prev_r);
                chk($sformatf("stall hold ov c%0d", c), {31'd0, ov3}, {31'd0, prev_ov});
            end
        end
        chk("stall count", got_val.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_val.size()) begin
                chk($sformatf("stall value %0d", k), got_val[k], k + 1);
                chk($sformatf("stall cycle %0d", k), got_cyc[k], (k == 0) ? 5 : k + 6);
            end
        end

        // Random stream on both instances, scoreboarded in order.
        for (int c = 0; c < 400; c++) begin
            logic [33:0] xr;
            logic        vr, cr;
            xr = rand_x();
            vr = ($urandom_range(0, 9) < 7);
            cr = ($urandom_range(0, 3) != 0);
            x1 = xr; x3 = xr; v1 = vr; v3 = vr; ce1 = cr; ce3 = cr;
            if (cr && vr) begin
                model(xr, er, eb);
                q1.push_back({eb, er});
                q3.push_back({eb, er});
            end
            @(posedge clk); #1;
            if (cr && ov1) begin
                $display("rand c=%0d dut1 R=%h inv=%b", c, r1, inv1);
                if (q1.size() == 0) chk("rand1 unexpected output", 32'd1, 32'd0);
                else begin
                    e33 = q1.pop_front();
                    chk("rand1 R", r1, e33[31:0]);
                    chk("rand1 invalid", {31'd0, inv1}, {31'd0, e33[32]});
                end
            end
            if (cr && ov3) begin
                $display("rand c=%0d dut3 R=%h inv=%b", c, r3, inv3);
                if (q3.size() == 0) chk("rand3 unexpected output", 32'd1, 32'd0);
                else begin
                    e33 = q3.pop_front();
                    chk("rand3 R", r3, e33[31:0]);
                    chk("rand3 invalid", {31'd0, inv3}, {31'd0, e33[32]});
                end
            end
        end
        v1 = 1'b0; v3 = 1'b0; ce1 = 1'b1; ce3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ov1) begin
                if (q1.size() == 0) chk("drain1 unexpected output", 32'd1, 32'd0);
                else begin
                    e33 = q1.pop_front();
                    chk("drain1 R", r1, e33[31:0]);
                end
            end
            if (ov3) begin
                if (q3.size() == 0) chk("drain3 unexpected output", 32'd1, 32'd0);
                else begin
                    e33 = q3.pop_front();
                    chk("drain3 R", r3, e33[31:0]);
                    chk("drain3 invalid", {31'd0, inv3}, {31'd0, e33[32]});
                end
            end
        end
        chk("rand1 leftover", q1.size(), 32'd0);
        chk("rand3 leftover", q3.size(), 32'd0);

        // Asynchronous reset with three operands in flight.
        x3 = mk(2'b11, 1'b0, 8'd255, 23'd1); v3 = 1'b1;
        @(posedge clk); #1;
        x3 = mk(2'b01, 1'b0, 8'd127, 23'd0);
        @(posedge clk); #1;
        x3 = mk(2'b01, 1'b0, 8'd128, 23'd0);
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("pre-reset ov3", {31'd0, ov3}, 32'd1);
        chk("pre-reset inv3", {31'd0, inv3}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset R=%h ov=%b inv=%b", r3, ov3, inv3);
        chk("async reset ov3", {31'd0, ov3}, 32'd0);
        chk("async reset r3", r3, 32'd0);
        chk("async reset inv3", {31'd0, inv3}, 32'd0);
        #3 rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ov3) stale++;
        end
        chk("no stale after reset", stale, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
